// File: rtl/pa_clint_mh.sv
// Core-local interruptor: per-hart software/timer/external interrupts plus a
// 64-bit prescaled mtime counter, accessed over a single-cycle request port.
module pa_clint_mh #(
  parameter int unsigned HART_NUM = 2,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic [1:0]          cpu_clint_mode,
  input  logic                tcipif_clint_sel,
  input  logic                tcipif_clint_write,
  input  logic [15:0]         tcipif_clint_addr,
  input  logic [31:0]         tcipif_clint_wdata,
  input  logic [HART_NUM-1:0] sysio_clint_me_int,
  output logic                clint_tcipif_cmplt,
  output logic [31:0]         clint_tcipif_rdata,
  output logic [HART_NUM-1:0] clint_cpu_ms_int,
  output logic [HART_NUM-1:0] clint_cpu_mt_int,
  output logic [HART_NUM-1:0] clint_cpu_me_int
);

  localparam int unsigned PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] MSIP_BASE = 16'h0000;
  localparam logic [15:0] CMP_BASE  = 16'h4000;
  localparam logic [15:0] MTIME_LO  = 16'hBFF8;
  localparam logic [15:0] MTIME_HI  = 16'hBFFC;

  logic [63:0]         mtime_q;
  logic [PS_W-1:0]     presc_q;
  logic [HART_NUM-1:0] msip_q;
  logic [HART_NUM-1:0] mt_int_q;
  logic [HART_NUM-1:0] me_int_q;
  logic [63:0]         mtimecmp_q [HART_NUM];
  logic                cmplt_q;
  logic [31:0]         rdata_q;

  logic                m_acc;
  logic                wr_en;
  logic                presc_wrap;
  logic [HART_NUM-1:0] hit_msip;
  logic [HART_NUM-1:0] hit_cmp_lo;
  logic [HART_NUM-1:0] hit_cmp_hi;
  logic                hit_mt_lo;
  logic                hit_mt_hi;
  logic [31:0]         rd_val;

  assign m_acc      = tcipif_clint_sel && (cpu_clint_mode == 2'b11);
  assign wr_en      = m_acc && tcipif_clint_write;
  assign presc_wrap = (presc_q == PS_W'(TICK_DIV - 1));

  // Address decode and read mux; unmapped addresses read as zero
  always_comb begin
    hit_msip   = '0;
    hit_cmp_lo = '0;
    hit_cmp_hi = '0;
    rd_val     = '0;
    hit_mt_lo  = (tcipif_clint_addr == MTIME_LO);
    hit_mt_hi  = (tcipif_clint_addr == MTIME_HI);
    for (int unsigned h = 0; h < HART_NUM; h++) begin
      hit_msip[h]   = (tcipif_clint_addr == MSIP_BASE + 16'(4 * h));
      hit_cmp_lo[h] = (tcipif_clint_addr == CMP_BASE + 16'(8 * h));
      hit_cmp_hi[h] = (tcipif_clint_addr == CMP_BASE + 16'(8 * h + 4));
      if (hit_msip[h])   rd_val = {31'd0, msip_q[h]};
      if (hit_cmp_lo[h]) rd_val = mtimecmp_q[h][31:0];
      if (hit_cmp_hi[h]) rd_val = mtimecmp_q[h][63:32];
    end
    if (hit_mt_lo) rd_val = mtime_q[31:0];
    if (hit_mt_hi) rd_val = mtime_q[63:32];
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      mtime_q  <= '0;
      presc_q  <= '0;
      msip_q   <= '0;
      mt_int_q <= '0;
      me_int_q <= '0;
      cmplt_q  <= 1'b0;
      rdata_q  <= '0;
      for (int unsigned h = 0; h < HART_NUM; h++) mtimecmp_q[h] <= '1;
    end else begin
      cmplt_q  <= tcipif_clint_sel;
      rdata_q  <= (m_acc && !tcipif_clint_write) ? rd_val : 32'd0;
      me_int_q <= sysio_clint_me_int;

      // A software load of mtime takes precedence over the tick
      if (wr_en && (hit_mt_lo || hit_mt_hi)) begin
        if (hit_mt_lo) mtime_q[31:0]  <= tcipif_clint_wdata;
        else           mtime_q[63:32] <= tcipif_clint_wdata;
        presc_q <= '0;
      end else if (presc_wrap) begin
        presc_q <= '0;
        mtime_q <= mtime_q + 64'd1;
      end else begin
        presc_q <= presc_q + PS_W'(1);
      end

      for (int unsigned h = 0; h < HART_NUM; h++) begin
        mt_int_q[h] <= (mtime_q >= mtimecmp_q[h]);
        if (wr_en && hit_msip[h])   msip_q[h]             <= tcipif_clint_wdata[0];
        if (wr_en && hit_cmp_lo[h]) mtimecmp_q[h][31:0]  <= tcipif_clint_wdata;
        if (wr_en && hit_cmp_hi[h]) mtimecmp_q[h][63:32] <= tcipif_clint_wdata;
      end
    end
  end

  // Reset in the completion cycle withdraws the response
  assign clint_tcipif_cmplt = cmplt_q & cpurst_b;
  assign clint_tcipif_rdata = rdata_q & {32{cpurst_b}};
  assign clint_cpu_ms_int   = msip_q;
  assign clint_cpu_mt_int   = mt_int_q;
  assign clint_cpu_me_int   = me_int_q;

endmodule

// File: tb/tb_pa_clint_mh.sv
// Bench for pa_clint_mh: two instances (tick divider 1 and 4) checked every
// cycle against a behavioural model driven by directed and random accesses.
module tb_pa_clint_mh;

  localparam int unsigned HN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b11;
  logic          sel = 1'b0;
  logic          wr = 1'b0;
  logic [15:0]   addr = 16'h0;
  logic [31:0]   wdata = 32'h0;
  logic [HN-1:0] me_in = '0;

  logic          cmplt  [2];
  logic [31:0]   rdata  [2];
  logic [HN-1:0] ms_int [2];
  logic [HN-1:0] mt_int [2];
  logic [HN-1:0] me_int [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pa_clint_mh #(.HART_NUM(HN), .TICK_DIV(1)) u_dut1 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .cpu_clint_mode(mode),
    .tcipif_clint_sel(sel), .tcipif_clint_write(wr), .tcipif_clint_addr(addr),
    .tcipif_clint_wdata(wdata), .sysio_clint_me_int(me_in),
    .clint_tcipif_cmplt(cmplt[0]), .clint_tcipif_rdata(rdata[0]),
    .clint_cpu_ms_int(ms_int[0]), .clint_cpu_mt_int(mt_int[0]), .clint_cpu_me_int(me_int[0])
  );

  pa_clint_mh #(.HART_NUM(HN), .TICK_DIV(4)) u_dut4 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .cpu_clint_mode(mode),
    .tcipif_clint_sel(sel), .tcipif_clint_write(wr), .tcipif_clint_addr(addr),
    .tcipif_clint_wdata(wdata), .sysio_clint_me_int(me_in),
    .clint_tcipif_cmplt(cmplt[1]), .clint_tcipif_rdata(rdata[1]),
    .clint_cpu_ms_int(ms_int[1]), .clint_cpu_mt_int(mt_int[1]), .clint_cpu_me_int(me_int[1])
  );

  // Model: mtime = last loaded value + elapsed cycles / divider
  int unsigned   div_of [2] = '{1, 4};
  logic [63:0]   m_base [2];
  int unsigned   m_cyc  [2];
  logic [63:0]   m_now  [2];
  logic [HN-1:0] m_msip;
  logic [63:0]   m_cmp  [HN];
  logic          e_cmplt;
  logic          e_rd_chk;
  logic [31:0]   e_rdata [2];
  logic [HN-1:0] e_ms;
  logic [HN-1:0] e_me;
  logic [HN-1:0] e_mt [2];
  bit            model_valid = 1'b0;

  function automatic logic [63:0] mt_now(input int i);
    return m_base[i] + 64'(m_cyc[i] / div_of[i]);
  endfunction

  function automatic logic [31:0] read_val(input int i, input logic [15:0] a, input logic [1:0] md);
    logic [63:0] t;
    t = mt_now(i);
    if (md != 2'b11) return 32'd0;
    if (a == 16'hBFF8) return t[31:0];
    if (a == 16'hBFFC) return t[63:32];
    for (int h = 0; h < int'(HN); h++) begin
      if (a == 16'(4 * h))            return {31'd0, m_msip[h]};
      if (a == 16'(16'h4000 + 8 * h)) return m_cmp[h][31:0];
      if (a == 16'(16'h4004 + 8 * h)) return m_cmp[h][63:32];
    end
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_base[i] = 64'd0; m_cyc[i] = 0; e_rdata[i] = 32'd0; e_mt[i] = '0;
      end
      for (int h = 0; h < int'(HN); h++) m_cmp[h] = '1;
      m_msip = '0; e_cmplt = 1'b0; e_rd_chk = 1'b1; e_ms = '0; e_me = '0;
      model_valid = 1'b1;
    end else begin
      e_cmplt  = sel;
      e_rd_chk = !(sel && wr);
      e_me     = me_in;
      for (int i = 0; i < 2; i++) begin
        m_now[i]   = mt_now(i);
        e_rdata[i] = (sel && !wr) ? read_val(i, addr, mode) : 32'd0;
        for (int h = 0; h < int'(HN); h++) e_mt[i][h] = (m_now[i] >= m_cmp[h]);
        m_cyc[i]++;
      end
      if (sel && wr && mode == 2'b11) begin
        for (int i = 0; i < 2; i++) begin
          if (addr == 16'hBFF8) begin m_base[i] = {m_now[i][63:32], wdata}; m_cyc[i] = 0; end
          if (addr == 16'hBFFC) begin m_base[i] = {wdata, m_now[i][31:0]}; m_cyc[i] = 0; end
        end
        for (int h = 0; h < int'(HN); h++) begin
          if (addr == 16'(4 * h))            m_msip[h]       = wdata[0];
          if (addr == 16'(16'h4000 + 8 * h)) m_cmp[h][31:0]  = wdata;
          if (addr == 16'(16'h4004 + 8 * h)) m_cmp[h][63:32] = wdata;
        end
      end
      e_ms = m_msip;
    end
  end

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, inst, act, exp);
    end
  endtask

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        check("cmplt", i, 64'(cmplt[i]), 64'(e_cmplt & rst_n));
        if (e_rd_chk) check("rdata", i, 64'(rdata[i]), rst_n ? 64'(e_rdata[i]) : 64'd0);
        check("ms_int", i, 64'(ms_int[i]), 64'(e_ms));
        check("mt_int", i, 64'(mt_int[i]), 64'(e_mt[i]));
        check("me_int", i, 64'(me_int[i]), 64'(e_me));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic acc(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [1:0] md);
    sel = 1'b1; wr = w; addr = a; wdata = d; mode = md;
    tick();
    sel = 1'b0; wr = 1'b0; mode = 2'b11;
  endtask

  logic [15:0] pool [16] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h4000, 16'h4004,
                             16'h4008, 16'h400C, 16'h4010, 16'h4014, 16'hBFF8, 16'hBFFC,
                             16'hBFF4, 16'h1234, 16'h8000, 16'hC000};

  initial begin
    tick(); tick();
    rst_n = 1'b1;

    // Divided tick: 1 after 4 cycles, 2 after 8, high word 0
    repeat (4) tick();
    check("pin_div4_4cyc", 1, mt_now(1), 64'd1);
    check("pin_div1_4cyc", 0, mt_now(0), 64'd4);
    repeat (4) tick();
    check("pin_div4_8cyc", 1, mt_now(1), 64'd2);
    acc(1'b0, 16'hBFF8, 32'd0, 2'b11);
    check("pin_rd_mtlo", 1, 64'(e_rdata[1]), 64'd2);
    acc(1'b0, 16'hBFFC, 32'd0, 2'b11);
    check("pin_rd_mthi", 1, 64'(e_rdata[1]), 64'd0);

    // Back-to-back reads of mtimecmp[0] reset value
    acc(1'b0, 16'h4000, 32'd0, 2'b11);
    check("pin_cmp_lo", 0, 64'(e_rdata[0]), 64'hFFFF_FFFF);
    acc(1'b0, 16'h4004, 32'd0, 2'b11);
    check("pin_cmp_hi", 0, 64'(e_rdata[0]), 64'hFFFF_FFFF);

    // msip write in machine mode, then ignored write in user mode
    acc(1'b1, 16'h0004, 32'd1, 2'b11);
    check("pin_msip_set", 0, 64'(e_ms), 64'd2);
    acc(1'b1, 16'h0004, 32'd0, 2'b00);
    check("pin_msip_umode", 0, 64'(e_ms), 64'd2);
    check("pin_umode_cmplt", 0, 64'(e_cmplt), 64'd1);

    // mtime carry from low into high word
    acc(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 2'b11);
    acc(1'b1, 16'hBFFC, 32'h0, 2'b11);
    check("pin_mt_load", 0, mt_now(0), 64'h0000_0000_FFFF_FFFE);
    tick(); tick();
    check("pin_mt_carry", 0, mt_now(0), 64'h0000_0001_0000_0000);
    acc(1'b0, 16'hBFFC, 32'd0, 2'b11);

    // Timer interrupt on hart 1 only
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    acc(1'b1, 16'h400C, 32'h0, 2'b11);
    acc(1'b1, 16'h4008, 32'h10, 2'b11);
    for (int k = 0; k < 40 && !e_mt[0][1]; k++) tick();
    check("pin_mt1_rise", 0, 64'(e_mt[0][1]), 64'd1);
    check("pin_mt1_time", 0, mt_now(0), 64'h11);
    check("pin_mt0_low", 0, 64'(e_mt[0][0]), 64'd0);
    tick();

    // Reset in the completion cycle of an out-of-range read
    acc(1'b0, 16'h0008, 32'd0, 2'b11);
    rst_n = 1'b0;
    check("pin_oor_rdata", 0, 64'(e_rdata[0]), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      me_in = HN'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) != 0) begin
        sel   = 1'b1;
        wr    = 1'($urandom_range(0, 1));
        addr  = pool[$urandom_range(0, 15)];
        mode  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        wdata = ($urandom_range(0, 7) == 0) ? $urandom
              : (addr[2] ? 32'd0 : 32'($urandom_range(0, 3000)));
      end else begin
        sel = 1'b0; wr = 1'b0;
      end
      tick();
    end
    sel = 1'b0; wr = 1'b0; rst_n = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pa_clint_mh.md
PA_CLINT_MH -- requirements
Module: pa_clint_mh

Interface
REQ-001 Parameter HART_NUM, default 2, number of harts served (1..8).
REQ-002 Parameter TICK_DIV, default 1, forever_cpuclk cycles per mtime increment (1..256).
REQ-003 forever_cpuclk  in  1  sole clock, all state rising-edge.
REQ-004 cpurst_b  in  1  reset, synchronous and active-low.
REQ-005 cpu_clint_mode  in  2  privilege mode of the requester, 2'b11 = machine.
REQ-006 tcipif_clint_sel  in  1  access request, one-cycle pulse per access.
REQ-007 tcipif_clint_write  in  1  1 = write, 0 = read; qualified by sel.
REQ-008 tcipif_clint_addr  in  16  byte address, word aligned.
REQ-009 tcipif_clint_wdata  in  32  write data.
REQ-010 sysio_clint_me_int  in  HART_NUM  external interrupt per hart.
REQ-011 clint_tcipif_cmplt  out  1  access complete.
REQ-012 clint_tcipif_rdata  out  32  read data, valid with cmplt.
REQ-013 clint_cpu_ms_int / clint_cpu_mt_int / clint_cpu_me_int  out  HART_NUM each  software / timer / external interrupt per hart.

Function
REQ-014 Address map: msip[h] at 0x0000+4h; mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h; mtime low 0xBFF8, high 0xBFFC.
REQ-015 msip[h] stores bit 0 only; reads return {31'b0, msip[h]}; ms_int[h] = msip[h].
REQ-016 mtime is an internal 64-bit counter; a prescaler counts 0..TICK_DIV-1 and mtime increments by 1 in the cycle the prescaler wraps; TICK_DIV=1 increments every cycle.
REQ-017 Increment carries from low into high word; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-018 Write to either mtime word loads that word, leaves the other word unchanged, suppresses that cycle's increment, and clears the prescaler.
REQ-019 mt_int[h] is registered: set one cycle after mtime >= mtimecmp[h] (64-bit unsigned compare), cleared one cycle after the compare fails.
REQ-020 me_int[h] is sysio_clint_me_int[h] registered by one cycle.
REQ-021 Handshake: cmplt asserts exactly one cycle after sel, for one cycle; back-to-back sel every cycle is legal and yields cmplt every cycle.
REQ-022 rdata is registered, captured from register state in the sel cycle (pre-write), driven only while cmplt=1, 0 otherwise.
REQ-023 Writes take effect at the clock edge ending the sel cycle.
REQ-024 Unmapped address, or msip/mtimecmp index >= HART_NUM: write ignored, read returns 0, cmplt still asserted.
REQ-025 cpu_clint_mode != 2'b11: write ignored, read returns 0, cmplt still asserted.
REQ-026 Writing one mtimecmp word does not alter the other; the interrupt compare uses the full updated value from the following cycle.

Reset
REQ-027 When cpurst_b=0 at a clock edge: mtime=0, prescaler=0, msip=0, mtimecmp=all ones, all interrupt outputs 0, cmplt=0, rdata=0.
REQ-028 Reset asserted in the cycle after sel cancels the pending cmplt; no completion is issued for that access.
REQ-029 State is undefined between power-up and the first clock edge with cpurst_b=0.

Verification
REQ-030 TICK_DIV=4, reset released -> mtime low reads 1 after 4 cycles, 2 after 8; hi stays 0.
REQ-031 Write mtime low 0xFFFF_FFFE, hi 0 (TICK_DIV=1) -> two increments later mtime = 0x1_0000_0000.
REQ-032 mtimecmp[1] = 0x0000_0000_0000_0010, mtime counting from 0 -> mt_int[1] rises the cycle after mtime reaches 0x10, mt_int[0] stays 0.
REQ-033 Machine-mode write 1 to 0x0004 -> ms_int[1]=1 next cycle; same write with mode 2'b00 -> no change, cmplt still 1.
REQ-034 Back-to-back reads 0x4000, 0x4004 after reset -> cmplt two consecutive cycles, rdata 0xFFFF_FFFF both.
REQ-035 Read of 0x0008 with HART_NUM=2, then reset in completion cycle -> rdata 0 and cmplt 0 throughout.
